// File: rtl/long_mul_unit_pkg.sv
// Shared definitions for the iterative long multiplier: FSM states, the
// default operand width and the {N,Z} flag bit positions used by condition logic.
package long_mul_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int N_IDX     = 1;
  localparam int Z_IDX     = 0;

endpackage

// File: rtl/long_mul_unit.sv
// Radix-2 shift-add multiplier for MUL/UMULL/SMULL: sign-magnitude iteration
// over WIDTH cycles, 2*WIDTH-bit product and {N,Z} flags behind a start/busy/done handshake.
module long_mul_unit
  import long_mul_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             LongFlag,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  mul_state_t state_q, state_nx;
  logic [CNTW-1:0] cnt_q;
  logic [WIDTH:0]  acc_q;
  logic [WIDTH-1:0] mreg_q, maga_q;
  logic            negres_q, long_q;

  logic              accept, last;
  logic signed [WIDTH-1:0] srca_s, srcb_s;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [1:0]        flags_nx;

  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == DONE);
  assign accept = Start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (cnt_q == CNTW'(WIDTH - 1));

  // Operand magnitudes; negating the most negative value yields 2^(WIDTH-1), still exact unsigned.
  assign srca_s = SrcA;
  assign srcb_s = SrcB;
  assign mag_a  = (Signed && (srca_s < 0)) ? WIDTH'(-srca_s) : SrcA;
  assign mag_b  = (Signed && (srcb_s < 0)) ? WIDTH'(-srcb_s) : SrcB;

  // One iteration: conditional add keeps the carry, then {sum, mreg} shifts right by one.
  assign sum      = acc_q + (mreg_q[0] ? {1'b0, maga_q} : '0);
  assign prod_mag = {sum, mreg_q[WIDTH-1:1]};
  assign prod     = negres_q ? (~prod_mag + 1'b1) : prod_mag;

  always_comb begin
    flags_nx        = '0;
    flags_nx[N_IDX] = long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
    flags_nx[Z_IDX] = long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = Start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= '0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CNTW'(1);
        if (last) begin
          ResultLo <= prod[WIDTH-1:0];
          ResultHi <= prod[2*WIDTH-1:WIDTH];
          MulFlags <= flags_nx;
        end
      end
    end
  end

  // Datapath registers; only meaningful between acceptance and the DONE edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      maga_q   <= mag_a;
      mreg_q   <= mag_b;
      acc_q    <= '0;
      negres_q <= Signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
      long_q   <= LongFlag;
    end else if (state_q == RUN) begin
      acc_q  <= {1'b0, sum[WIDTH:1]};
      mreg_q <= {sum[0], mreg_q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_long_mul_unit.sv
// Directed-vector bench for long_mul_unit; expected products are queued at
// issue time and a monitor checks each Done pulse against the queue head.
module tb_long_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, Signed, LongFlag;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] ResultLo, ResultHi;
  logic [1:0]  MulFlags;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  fl;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  long_mul_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .Signed(Signed), .LongFlag(LongFlag),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .MulFlags(MulFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("result_hi", {32'd0, ResultHi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, ResultLo}, {32'd0, e.lo});
        chk("mul_flags", {62'd0, MulFlags}, {62'd0, e.fl});
      end
    end
  end

  // Drives one Start pulse; the Done is expected 33 edges after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic lf, input bit push, input logic [31:0] hi,
                       input logic [31:0] lo, input logic [1:0] fl);
    exp_t e;
    @(negedge clk);
    Start = 1'b1; SrcA = a; SrcB = b; Signed = sg; LongFlag = lf;
    if (push) begin
      e.hi = hi; e.lo = lo; e.fl = fl; e.cyc = cyc + 33;
      q.push_back(e);
    end
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Signed = $urandom_range(0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Signed = 1'b0; LongFlag = 1'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_result", {ResultHi, ResultLo}, 64'd0);
    chk("reset_flags", {62'd0, MulFlags}, 64'd0);
    reset = 1'b0;

    // 3*5 with latency checks on Busy.
    issue(32'd3, 32'd5, 1'b0, 1'b1, 1, 32'h0, 32'hF, 2'b00);
    chk("busy_first", {63'd0, Busy}, 64'd1);
    repeat (31) @(negedge clk);
    chk("busy_last", {63'd0, Busy}, 64'd1);
    @(negedge clk);
    chk("busy_off_at_done", {63'd0, Busy}, 64'd0);
    wait_drain();

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1, 32'hFFFFFFFE, 32'h00000001, 2'b10);
    wait_drain();
    issue(32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 2'b10);
    wait_drain();
    issue(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1, 32'h40000000, 32'h0, 2'b00);
    wait_drain();
    issue(32'h10000, 32'h10000, 1'b0, 1'b0, 1, 32'h1, 32'h0, 2'b01);
    wait_drain();
    issue(32'h10000, 32'h10000, 1'b0, 1'b1, 1, 32'h1, 32'h0, 2'b00);
    wait_drain();
    issue(32'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 1, 32'hFFFFFFFF, 32'hFFFFFFF9, 2'b10);
    wait_drain();
    issue(32'hFFFFFFFD, 32'hFFFFFFFC, 1'b1, 1'b1, 1, 32'h0, 32'hC, 2'b00);
    wait_drain();
    issue(32'd0, 32'd5, 1'b0, 1'b1, 1, 32'h0, 32'h0, 2'b01);
    wait_drain();

    // Start re-pulsed mid-run is ignored; Start held in the Done cycle chains the next op.
    issue(32'd100, 32'd200, 1'b0, 1'b1, 1, 32'h0, 32'h4E20, 2'b00);
    repeat (8) @(negedge clk);
    issue(32'd9, 32'd9, 1'b0, 1'b1, 0, 32'h0, 32'h0, 2'b00);
    begin
      int n = 0;
      while (!Done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!Done) chk("b2b_done_timeout", 64'd0, 64'd1);
    end
    begin
      exp_t e;
      Start = 1'b1; SrcA = 32'h12345678; SrcB = 32'h10; Signed = 1'b0; LongFlag = 1'b1;
      e.hi = 32'h1; e.lo = 32'h23456780; e.fl = 2'b00; e.cyc = cyc + 33;
      q.push_back(e);
      @(negedge clk);
      Start = 1'b0;
      chk("b2b_done_drop", {63'd0, Done}, 64'd0);
      chk("b2b_busy_rise", {63'd0, Busy}, 64'd1);
    end
    wait_drain();

    // Reset mid-operation: abort without a Done, then a fresh run.
    issue(32'd11, 32'd13, 1'b0, 1'b1, 0, 32'h0, 32'h0, 2'b00);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_result", {ResultHi, ResultLo}, 64'd0);
    chk("abort_flags", {62'd0, MulFlags}, 64'd0);
    repeat (40) @(negedge clk);
    issue(32'd6, 32'd7, 1'b0, 1'b0, 1, 32'h0, 32'h2A, 2'b00);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("result_hold", {ResultHi, ResultLo}, 64'h2A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
